// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART Tx core among NUM_REQ byte requesters.
// Define UART_ARB_TAG_EN to prefix each data byte with a source-tag byte.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no transfer owned; arbitrate when some req is high and ack is low
// TAG_ISSUE  | (tag build) wait for core idle, strobe the tag byte
// TAG_WAIT   | (tag build) tag byte shifting; on done switch tx_data to the data byte
// ISSUE      | wait for core idle, strobe the data byte
// WAIT       | data byte shifting; on done ack the owner and release
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 busy,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  input  logic                 tx_done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef UART_ARB_TAG_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TAG_ISSUE,
    ST_TAG_WAIT,
    ST_ISSUE,
    ST_WAIT
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
`ifdef UART_ARB_TAG_EN
  logic [7:0]         data_q, data_d;
`endif

  logic [7:0]         req_bytes [NUM_REQ];
  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  // search begins one past the previous owner so a re-requester goes last
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last_q) + off) % NUM_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
`ifdef UART_ARB_TAG_EN
    data_d     = data_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // the cycle carrying ack must not re-arbitrate, or the just-served
        // requester could win again before it has seen its ack
        if (win_vld && (ack_q == '0)) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          last_d           = win_idx;
`ifdef UART_ARB_TAG_EN
          data_d    = req_bytes[win_idx];
          tx_data_d = {4'hA, 1'b0, 3'(win_idx)};
          state_d   = ST_TAG_ISSUE;
`else
          tx_data_d = req_bytes[win_idx];
          state_d   = ST_ISSUE;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      ST_TAG_ISSUE: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = ST_TAG_WAIT;
        end
      end
      ST_TAG_WAIT: begin
        if (tx_done) begin
          tx_data_d = data_q;
          state_d   = ST_ISSUE;
        end
      end
`endif
      ST_ISSUE: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tx_done) begin
          ack_d   = grant_q;
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      last_q     <= IDX_W'(NUM_REQ - 1);
      grant_q    <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
`ifdef UART_ARB_TAG_EN
      data_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
`ifdef UART_ARB_TAG_EN
      data_q     <= data_d;
`endif
    end
  end

  assign grant    = grant_q;
  assign ack      = ack_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a cycle-count model of the Tx core.
// Honours UART_ARB_TAG_EN when the design is built with it.
module tb_uart_tx_arbiter;

  localparam int CORE_LEN = 10;
`ifdef UART_ARB_TAG_EN
  localparam int SPX = 2;
`else
  localparam int SPX = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic        core_busy;
  logic        ext_busy;

  assign tx_busy = core_busy | ext_busy;

  uart_tx_arbiter #(.NUM_REQ(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .ack      (ack),
    .busy     (busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_start = 0;
  int n_ack = 0;
  int cyc = 0;
  int last_start_cyc = 0;
  int core_cnt = 0;

  logic [7:0] exp_data_q [$];
  logic [3:0] exp_grant_q [$];
  logic [3:0] exp_ack_q [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_xfer(input int idx, input logic [7:0] d);
    logic [3:0] g;
    g = 4'(1 << idx);
`ifdef UART_ARB_TAG_EN
    exp_data_q.push_back({4'hA, 1'b0, 3'(idx)});
    exp_grant_q.push_back(g);
`endif
    exp_data_q.push_back(d);
    exp_grant_q.push_back(g);
    exp_ack_q.push_back(g);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    int seen = 0;
    int t = 0;
    while (seen < n && t < budget) begin
      @(negedge clk);
      t++;
      if (tx_start) seen++;
    end
    if (seen < n) check_val(tag, 32'(seen), 32'(n));
  endtask

  task automatic wait_ack(input int budget, input string tag);
    int t = 0;
    logic hit = 1'b0;
    while (!hit && t < budget) begin
      @(negedge clk);
      t++;
      if (ack != 4'b0) hit = 1'b1;
    end
    if (!hit) check_val(tag, 32'(0), 32'(1));
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Tx core: busy for CORE_LEN cycles after a start, then a one-cycle done
  initial begin
    core_busy = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          core_busy = 1'b0;
          tx_done   = 1'b1;
        end
      end else if (tx_start) begin
        core_cnt  = CORE_LEN;
        core_busy = 1'b1;
      end
    end
  end

  // scoreboard consumer: every start and every ack must match the next expectation
  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      n_start++;
      last_start_cyc = cyc;
      if (exp_data_q.size() == 0) begin
        check_val("start_unexpected", 32'(exp_data_q.size()), 32'(1));
      end else begin
        check_val("tx_data_at_start", 32'(tx_data), 32'(exp_data_q.pop_front()));
        check_val("grant_at_start", 32'(grant), 32'(exp_grant_q.pop_front()));
      end
    end
    if (ack != 4'b0) begin
      n_ack++;
      if (exp_ack_q.size() == 0) begin
        check_val("ack_unexpected", 32'(exp_ack_q.size()), 32'(1));
      end else begin
        check_val("ack_owner", 32'(ack), 32'(exp_ack_q.pop_front()));
      end
    end
  end

  initial begin
    int base;
    reset    = 1'b0;
    req      = 4'b0;
    req_data = 32'h0;
    ext_busy = 1'b0;

    repeat (2) @(negedge clk);
    check_val("rst_grant", 32'(grant), 32'(0));
    check_val("rst_ack", 32'(ack), 32'(0));
    check_val("rst_tx_start", 32'(tx_start), 32'(0));
    check_val("rst_tx_data", 32'(tx_data), 32'(0));
    check_val("rst_busy", 32'(busy), 32'(0));
    tick();
    reset = 1'b1;

    // all requesters continuously: 0,1,2,3,0
    tick();
    base     = n_ack;
    req_data = 32'h13121110;
    req      = 4'hF;
    push_xfer(0, 8'h10);
    push_xfer(1, 8'h11);
    push_xfer(2, 8'h12);
    push_xfer(3, 8'h13);
    push_xfer(0, 8'h10);
    wait_starts(5 * SPX, 800, "rot_start_timeout");
    tick();
    req = 4'b0;
    wait_ack(100, "rot_ack_timeout");
    @(negedge clk);
    check_val("rot_ack_count", 32'(n_ack - base), 32'(5));

    // single request with latency checks
    tick();
    req_data[23:16] = 8'h5A;
    req             = 4'b0100;
    push_xfer(2, 8'h5A);
    @(posedge clk);
    @(negedge clk);
    check_val("t1_grant", 32'(grant), 32'b0100);
    check_val("t1_no_start_yet", 32'(tx_start), 32'(0));
    check_val("t1_busy", 32'(busy), 32'(1));
    @(negedge clk);
    check_val("t1_start", 32'(tx_start), 32'(1));
    wait_ack(200, "t1_ack_timeout");
    check_val("t1_ack_latency", 32'(cyc - last_start_cyc), 32'(CORE_LEN + 1));
    tick();
    req = 4'b0;
    @(negedge clk);
    check_val("t1_ack_single", 32'(ack), 32'(0));
    check_val("t1_busy_clear", 32'(busy), 32'(0));
    check_val("t1_grant_clear", 32'(grant), 32'(0));

    // core busy holds off the start strobe
    tick();
    ext_busy       = 1'b1;
    req_data[7:0]  = 8'h42;
    req            = 4'b0001;
    push_xfer(0, 8'h42);
    @(posedge clk);
    @(negedge clk);
    check_val("t3_grant", 32'(grant), 32'b0001);
    repeat (5) begin
      @(negedge clk);
      check_val("t3_hold", 32'(tx_start), 32'(0));
    end
    tick();
    ext_busy = 1'b0;
    @(negedge clk);
    check_val("t3_not_early", 32'(tx_start), 32'(0));
    @(negedge clk);
    check_val("t3_start", 32'(tx_start), 32'(1));
    @(negedge clk);
    check_val("t3_single", 32'(tx_start), 32'(0));
    wait_ack(200, "t3_ack_timeout");
    tick();
    req = 4'b0;

    // req dropped and data changed after grant
    tick();
    req_data[15:8] = 8'h3C;
    req            = 4'b0010;
    push_xfer(1, 8'h3C);
    @(posedge clk);
    @(negedge clk);
    check_val("t4_grant", 32'(grant), 32'b0010);
    tick();
    req            = 4'b0;
    req_data[15:8] = 8'hFF;
    wait_ack(200, "t4_ack_timeout");
    @(negedge clk);
    check_val("t4_idle", 32'(busy), 32'(0));

    // asynchronous reset while the start strobe is out
    tick();
    req_data[7:0] = 8'h77;
    req           = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    check_val("t5_grant", 32'(grant), 32'b0001);
    @(posedge clk);
    #1;
    check_val("t5_start_pre", 32'(tx_start), 32'(1));
    #2;
    reset = 1'b0;
    #1;
    check_val("t5_rst_grant", 32'(grant), 32'(0));
    check_val("t5_rst_ack", 32'(ack), 32'(0));
    check_val("t5_rst_tx_start", 32'(tx_start), 32'(0));
    check_val("t5_rst_tx_data", 32'(tx_data), 32'(0));
    check_val("t5_rst_busy", 32'(busy), 32'(0));
    req             = 4'b1000;
    req_data[31:24] = 8'h99;
    push_xfer(3, 8'h99);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("t5_regrant", 32'(grant), 32'b1000);
    wait_ack(200, "t5_ack_timeout");
    tick();
    req = 4'b0;

`ifdef UART_ARB_TAG_EN
    // tag byte precedes data, single ack
    tick();
    base           = n_start;
    req_data[15:8] = 8'hC3;
    req            = 4'b0010;
    push_xfer(1, 8'hC3);
    begin
      int ab;
      ab = n_ack;
      wait_ack(300, "tag_ack_timeout");
      tick();
      req = 4'b0;
      @(negedge clk);
      check_val("tag_start_count", 32'(n_start - base), 32'(2));
      check_val("tag_ack_count", 32'(n_ack - ab), 32'(1));
    end
`endif

    repeat (4) @(negedge clk);
    check_val("sb_data_left", 32'(exp_data_q.size()), 32'(0));
    check_val("sb_ack_left", 32'(exp_ack_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
